// File: rtl/wb_host_bridge.sv
// wb_host_bridge: Wishbone host port to NCH classic-Wishbone target channels.
// Optional REQ timeout is compiled in with `define WB_HOST_BRIDGE_TIMEOUT_EN.
module wb_host_bridge #(
    parameter int NCH = 4,
    parameter int CH_LSB = 28,
    parameter int TIMEOUT = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic              wbs_err_o,
    output logic [31:0]       wbs_dat_o,
    output logic [NCH-1:0]    m_cyc_o,
    output logic [NCH-1:0]    m_stb_o,
    output logic              m_we_o,
    output logic [3:0]        m_sel_o,
    output logic [31:0]       m_adr_o,
    output logic [31:0]       m_dat_o,
    input  logic [NCH*32-1:0] m_dat_i,
    input  logic [NCH-1:0]    m_ack_i,
    input  logic [NCH-1:0]    m_err_i,
    output logic              busy_o,
    output logic              timeout_o
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t         state, state_n;
    logic [CHW-1:0] idx, in_idx;
    logic           req, hit, sel_ack, sel_err, expire, load;
    logic           ack_n, err_n, to_n;
    logic [31:0]    sel_dat, dat_n;
    logic [NCH-1:0] cyc_n;

    assign req     = wbs_cyc_i & wbs_stb_i;
    assign in_idx  = wbs_adr_i[CH_LSB +: CHW];
    // The whole field above CH_LSB is decoded so out-of-range indices are caught.
    assign hit     = (wbs_adr_i >> CH_LSB) < 32'(NCH);
    assign sel_ack = m_ack_i[idx];
    assign sel_err = m_err_i[idx];
    assign sel_dat = m_dat_i[{idx, 5'd0} +: 32];

`ifdef WB_HOST_BRIDGE_TIMEOUT_EN
    logic [15:0] cnt;

    // Count REQ cycles from zero after each accept.
    always_ff @(posedge wb_clk_i)
        if (wb_rst_i || load) cnt <= '0;
        else if (state == REQ) cnt <= cnt + 16'd1;

    assign expire = cnt == 16'(TIMEOUT - 1);
`else
    assign expire = 1'b0;
`endif

    // State register.
    always_ff @(posedge wb_clk_i)
        state <= wb_rst_i ? IDLE : state_n;

    // Next state and next registered outputs; abort beats err beats ack beats timeout.
    always_comb begin
        state_n = state;
        cyc_n   = '0;
        ack_n   = 1'b0;
        err_n   = 1'b0;
        to_n    = 1'b0;
        dat_n   = wbs_dat_o;
        load    = 1'b0;
        case (state)
            IDLE: if (req) begin
                load    = 1'b1;
                state_n = hit ? REQ : RESP;
                err_n   = !hit;
                dat_n   = hit ? wbs_dat_o : ERR_DATA;
                if (hit) cyc_n[in_idx] = 1'b1;
            end
            REQ: begin
                state_n = !wbs_cyc_i ? IDLE : (sel_err | sel_ack | expire) ? RESP : REQ;
                cyc_n   = (state_n == REQ) ? m_cyc_o : '0;
                ack_n   = wbs_cyc_i & !sel_err & sel_ack;
                err_n   = wbs_cyc_i & (sel_err | (!sel_ack & expire));
                to_n    = wbs_cyc_i & !sel_err & !sel_ack & expire;
                dat_n   = !wbs_cyc_i ? wbs_dat_o :
                          (sel_err | sel_ack) ? sel_dat :
                          expire ? ERR_DATA : wbs_dat_o;
            end
            default: state_n = IDLE;
        endcase
    end

    // Registered host responses and per-channel strobes.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            m_cyc_o   <= '0;
            m_stb_o   <= '0;
            wbs_ack_o <= 1'b0;
            wbs_err_o <= 1'b0;
            timeout_o <= 1'b0;
            wbs_dat_o <= '0;
            busy_o    <= 1'b0;
        end else begin
            m_cyc_o   <= cyc_n;
            m_stb_o   <= cyc_n;
            wbs_ack_o <= ack_n;
            wbs_err_o <= err_n;
            timeout_o <= to_n;
            wbs_dat_o <= dat_n;
            busy_o    <= state_n != IDLE;
        end
    end

    // Request latch driving the shared channel bus.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            m_adr_o <= '0;
            m_dat_o <= '0;
            m_sel_o <= '0;
            m_we_o  <= 1'b0;
            idx     <= '0;
        end else if (load) begin
            m_adr_o <= wbs_adr_i;
            m_dat_o <= wbs_dat_i;
            m_sel_o <= wbs_sel_i;
            m_we_o  <= wbs_we_i;
            idx     <= in_idx;
        end
    end
endmodule
